// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_pkg / lsu_mem_ctrl
//
// Sequences one load/store at a time between the MEM pipeline stage and a
// single-port data-memory bus using a req/gnt/rvalid handshake. Generates byte
// enables and lane-replicated store data, formats load data with sign or zero
// extension, and stalls the pipeline until the access completes. An optional
// timeout (TIMEOUT_CYCLES > 0) terminates a hung access with err_o.
//
// Ports:
//   clk, arst_n        clock (rising edge), asynchronous active-low reset
//   req_valid_i        MEM stage holds a memory op
//   lsuop_i            lsu_pkg::lsuop_t encoding; codes 8..31 are no-ops
//   addr_i, wdata_i    byte address, right-aligned store data
//   stall_o            hold pipeline
//   misaligned_o       combinational misalignment flag (IDLE only)
//   rdata_o            formatted load result, held until next completion
//   rdata_valid_o      one-cycle completion pulse
//   err_o              one-cycle timeout pulse, coincident with rdata_valid_o
//   mem_req_o .. mem_wdata_o   bus request side
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i   bus response side
// -----------------------------------------------------------------------------
package lsu_pkg;
    typedef enum logic [4:0] {
        LSU_LB  = 5'd0,
        LSU_LH  = 5'd1,
        LSU_LW  = 5'd2,
        LSU_LBU = 5'd3,
        LSU_LHU = 5'd4,
        LSU_SB  = 5'd5,
        LSU_SH  = 5'd6,
        LSU_SW  = 5'd7
    } lsuop_t;
endpackage

module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        req_valid_i,
    input  logic [4:0]  lsuop_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        misaligned_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    import lsu_pkg::*;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    lsuop_t      op_q;
    logic [31:0] addr_q, wdata_q, cnt_q, rdata_q;
    logic        err_q;

    logic        op_valid, op_mis, accept, timeout;
    logic [3:0]  be;
    logic [31:0] lane_wdata, load_fmt;
    logic        is_store;

    // ---- incoming op decode ------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        op_valid = (lsuop_i <= 5'd7);
        op_mis   = 1'b0;
        case (lsuop_i)
            LSU_LH, LSU_LHU, LSU_SH: op_mis = addr_i[0];
            LSU_LW, LSU_SW:          op_mis = (addr_i[1:0] != 2'b00);
            default:                 op_mis = 1'b0;
        endcase
    end

    assign accept  = (state_q == S_IDLE) && req_valid_i && op_valid && !op_mis;
    // cnt_q counts cycles already spent in REQ/WAIT, so the access ends on
    // the TIMEOUT_CYCLES-th cycle after entering REQ.
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);

    // ---- store lanes / byte enables from the latched op ---------------------
    always_comb begin
        be         = 4'b1111;
        lane_wdata = 32'h0;
        is_store   = 1'b0;
        case (op_q)
            LSU_SB: begin
                be         = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
                is_store   = 1'b1;
            end
            LSU_SH: begin
                be         = 4'b0011 << {addr_q[1], 1'b0};
                lane_wdata = {2{wdata_q[15:0]}};
                is_store   = 1'b1;
            end
            LSU_SW: begin
                lane_wdata = wdata_q;
                is_store   = 1'b1;
            end
            default: ;
        endcase
    end

    // ---- load formatting from the raw bus word ------------------------------
    always_comb begin
        logic [31:0] shifted;
        logic [15:0] half;
        shifted  = mem_rdata_i >> {addr_q[1:0], 3'b000};
        half     = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        load_fmt = 32'h0;
        case (op_q)
            LSU_LB:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
            LSU_LBU: load_fmt = {24'h0, shifted[7:0]};
            LSU_LH:  load_fmt = {{16{half[15]}}, half};
            LSU_LHU: load_fmt = {16'h0, half};
            LSU_LW:  load_fmt = mem_rdata_i;
            default: load_fmt = 32'h0;
        endcase
    end

    // ---- FSM: state register ------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        // NOTE: sequential state always uses non-blocking (<=) so every
        // register samples pre-edge values regardless of statement order.
        if (!arst_n) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // ---- FSM: next state ----------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_REQ;
            S_REQ: begin
                if (timeout)        state_d = S_DONE;
                else if (mem_gnt_i) state_d = S_WAIT;
            end
            // A real response takes precedence over a coincident timeout.
            S_WAIT: if (mem_rvalid_i || timeout) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---- FSM: outputs -------------------------------------------------------
    always_comb begin
        stall_o       = accept || (state_q == S_REQ) || (state_q == S_WAIT);
        misaligned_o  = (state_q == S_IDLE) && req_valid_i && op_mis;
        rdata_o       = rdata_q;
        rdata_valid_o = (state_q == S_DONE);
        err_o         = (state_q == S_DONE) && err_q;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = 32'h0;
        mem_be_o      = 4'b0000;
        mem_wdata_o   = 32'h0;
        if (state_q == S_REQ) begin
            mem_req_o   = 1'b1;
            mem_we_o    = is_store;
            mem_addr_o  = {addr_q[31:2], 2'b00};
            mem_be_o    = be;
            mem_wdata_o = lane_wdata;
        end
    end

    // ---- datapath registers -------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            // NOTE: every datapath register is reset so an abandoned access
            // leaves no stale op, result or error flag behind.
            op_q    <= LSU_LB;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt_q   <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= lsuop_t'(lsuop_i);
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                cnt_q   <= 32'h0;
                err_q   <= 1'b0;
            end else if (state_q == S_REQ || state_q == S_WAIT) begin
                cnt_q <= cnt_q + 32'd1;
            end

            if (state_q == S_WAIT && mem_rvalid_i) begin
                rdata_q <= load_fmt;
                err_q   <= 1'b0;
            end else if ((state_q == S_REQ || state_q == S_WAIT) && timeout) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for lsu_mem_ctrl (TIMEOUT_CYCLES = 8).
// Inputs change and outputs are sampled 1-2 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        req_valid_i;
    logic [4:0]  lsuop_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, misaligned_o, rdata_valid_o, err_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int n_checks = 0;
    int n_err    = 0;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .req_valid_i   (req_valid_i),
        .lsuop_i       (lsuop_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .misaligned_o  (misaligned_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .err_o         (err_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_be_o      (mem_be_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic        we;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access: accept, REQ for gnt_dly+1 cycles, one WAIT cycle
    // with rvalid, then DONE. Leaves the DUT in IDLE at posedge+1.
    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int gnt_dly,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic exp_we, input logic [31:0] exp_res);
        req_valid_i = 1'b1;
        lsuop_i     = op;
        addr_i      = addr;
        wdata_i     = wdata;
        mem_gnt_i   = 1'b0;
        mem_rvalid_i = 1'b0;
        #1;
        check({name, " accept stall"}, stall_o, 1'b1);
        check({name, " accept no req"}, mem_req_o, 1'b0);
        check({name, " accept aligned"}, misaligned_o, 1'b0);
        tick();
        for (int d = 0; d <= gnt_dly; d++) begin
            mem_gnt_i    = (d == gnt_dly);
            mem_rvalid_i = 1'b1;  // same-cycle rvalid in REQ must be ignored
            mem_rdata_i  = 32'hBAD0_BAD0;
            #1;
            check({name, " req"}, mem_req_o, 1'b1);
            check({name, " addr"}, mem_addr_o, {addr[31:2], 2'b00});
            check({name, " be"}, mem_be_o, exp_be);
            check({name, " we"}, mem_we_o, exp_we);
            check({name, " wdata"}, mem_wdata_o, exp_wdata);
            check({name, " req stall"}, stall_o, 1'b1);
            check({name, " req no valid"}, rdata_valid_o, 1'b0);
            tick();
        end
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
        #1;
        check({name, " wait stall"}, stall_o, 1'b1);
        check({name, " wait req low"}, mem_req_o, 1'b0);
        check({name, " wait no valid"}, rdata_valid_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        #1;
        check({name, " done valid"}, rdata_valid_o, 1'b1);
        check({name, " done err"}, err_o, 1'b0);
        check({name, " done stall"}, stall_o, 1'b0);
        check({name, " rdata"}, rdata_o, exp_res);
        tick();
        req_valid_i = 1'b0;
        #1;
        check({name, " back idle"}, rdata_valid_o, 1'b0);
        check({name, " rdata held"}, rdata_o, exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{5'(LSU_SW),  32'h0000_0100, 32'hCAFE_F00D, 32'h1111_1111, 0, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0};
        vecs[1] = '{5'(LSU_SB),  32'h0000_0102, 32'h0000_00A7, 32'h1111_1111, 1, 4'b0100, 32'hA7A7_A7A7, 1'b1, 32'h0};
        vecs[2] = '{5'(LSU_SH),  32'h0000_0104, 32'hFFFF_1357, 32'h1111_1111, 0, 4'b0011, 32'h1357_1357, 1'b1, 32'h0};
        vecs[3] = '{5'(LSU_LH),  32'h0000_0106, 32'h0,         32'h8001_7FFF, 0, 4'b1111, 32'h0,         1'b0, 32'hFFFF_8001};
        vecs[4] = '{5'(LSU_LH),  32'h0000_0104, 32'h0,         32'h8001_7FFF, 1, 4'b1111, 32'h0,         1'b0, 32'h0000_7FFF};
        vecs[5] = '{5'(LSU_LB),  32'h0000_0101, 32'h0,         32'h1234_5678, 0, 4'b1111, 32'h0,         1'b0, 32'h0000_0056};
        vecs[6] = '{5'(LSU_LBU), 32'h0000_0102, 32'h0,         32'h00F0_0000, 0, 4'b1111, 32'h0,         1'b0, 32'h0000_00F0};
        vecs[7] = '{5'(LSU_LW),  32'h0000_0108, 32'h0,         32'hDEAD_BEEF, 1, 4'b1111, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[8] = '{5'(LSU_LHU), 32'h0000_010A, 32'h0,         32'hFACE_0000, 0, 4'b1111, 32'h0,         1'b0, 32'h0000_FACE};

        arst_n       = 1'b0;
        req_valid_i  = 1'b0;
        lsuop_i      = 5'd0;
        addr_i       = 32'h0;
        wdata_i      = 32'h0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        #12;
        check("reset stall", stall_o, 1'b0);
        check("reset req", mem_req_o, 1'b0);
        check("reset valid", rdata_valid_o, 1'b0);
        check("reset rdata", rdata_o, 32'h0);
        check("reset err", err_o, 1'b0);
        tick();
        arst_n = 1'b1;
        tick();

        // Test 1: LB sign extension, immediate grant/response
        run_op("t1_lb", 5'(LSU_LB), 32'h0000_1003, 32'h0, 32'h80FF_FF00, 0,
               4'b1111, 32'h0, 1'b0, 32'hFFFF_FF80);

        // Test 2: SH with grant delayed 4 cycles (5 REQ cycles)
        run_op("t2_sh", 5'(LSU_SH), 32'h0000_2002, 32'h1234_ABCD, 32'hDEAD_BEEF, 4,
               4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0);

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
                   vecs[i].rdata, vecs[i].gnt_dly, vecs[i].be, vecs[i].mwdata,
                   vecs[i].we, vecs[i].res);
        end

        // Test 3: misaligned ops are flagged and never reach the bus
        req_valid_i = 1'b1;
        lsuop_i = 5'(LSU_LW);  addr_i = 32'h0000_3001;
        #1;
        check("t3 lw mis", misaligned_o, 1'b1);
        check("t3 lw stall", stall_o, 1'b0);
        tick();
        check("t3 lw no req", mem_req_o, 1'b0);
        lsuop_i = 5'(LSU_LHU); addr_i = 32'h0000_3003;
        #1;
        check("t3 lhu mis", misaligned_o, 1'b1);
        check("t3 lhu stall", stall_o, 1'b0);
        tick();
        check("t3 lhu no req", mem_req_o, 1'b0);
        // Op code 9 is a no-op even at an odd address
        lsuop_i = 5'd9; addr_i = 32'h0000_3001;
        #1;
        check("noop mis", misaligned_o, 1'b0);
        check("noop stall", stall_o, 1'b0);
        tick();
        check("noop no req", mem_req_o, 1'b0);
        req_valid_i = 1'b0;
        run_op("t3_lhu", 5'(LSU_LHU), 32'h0000_3002, 32'h0, 32'hBEEF_0000, 0,
               4'b1111, 32'h0, 1'b0, 32'h0000_BEEF);

        // Test 5: reset while in WAIT, then a late rvalid
        req_valid_i = 1'b1; lsuop_i = 5'(LSU_LW); addr_i = 32'h0000_5000;
        tick();                       // now REQ
        req_valid_i = 1'b0;
        mem_gnt_i = 1'b1;
        tick();                       // now WAIT
        mem_gnt_i = 1'b0;
        #1;
        check("t5 in wait", stall_o, 1'b1);
        arst_n = 1'b0;
        #1;
        check("t5 rst stall", stall_o, 1'b0);
        check("t5 rst req", mem_req_o, 1'b0);
        check("t5 rst valid", rdata_valid_o, 1'b0);
        check("t5 rst rdata", rdata_o, 32'h0);
        check("t5 rst be", mem_be_o, 4'b0000);
        tick();
        arst_n = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        tick();
        mem_rvalid_i = 1'b0;
        check("t5 late rvalid", rdata_valid_o, 1'b0);
        check("t5 late rdata", rdata_o, 32'h0);
        check("t5 late stall", stall_o, 1'b0);

        // Test 6: back-to-back SB then LBU (second accepted right after DONE)
        run_op("t6_sb", 5'(LSU_SB), 32'h0000_0010, 32'h0000_005A, 32'h0, 0,
               4'b0001, 32'h5A5A_5A5A, 1'b1, 32'h0);
        run_op("t6_lbu", 5'(LSU_LBU), 32'h0000_0010, 32'h0, 32'h0000_005A, 0,
               4'b1111, 32'h0, 1'b0, 32'h0000_005A);

        // Test 4: timeout after 8 cycles in REQ/WAIT
        req_valid_i = 1'b1; lsuop_i = 5'(LSU_LW); addr_i = 32'h0000_4000;
        tick();                       // REQ cycle 1
        req_valid_i = 1'b0;
        mem_gnt_i = 1'b1;
        #1;
        check("t4 req", mem_req_o, 1'b1);
        tick();                       // WAIT cycles 2..8
        mem_gnt_i = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            check($sformatf("t4 no valid c%0d", c), rdata_valid_o, 1'b0);
            check($sformatf("t4 stall c%0d", c), stall_o, 1'b1);
            tick();
        end
        check("t4 err", err_o, 1'b1);
        check("t4 valid", rdata_valid_o, 1'b1);
        check("t4 rdata", rdata_o, 32'h0);
        check("t4 req dropped", mem_req_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b1;
        #1;
        check("t4 idle stall", stall_o, 1'b0);
        check("t4 idle no valid", rdata_valid_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b0;
        check("t4 stray no valid", rdata_valid_o, 1'b0);
        check("t4 stray no err", err_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Sequences one load/store operation at a time between the MEM pipeline stage and the single-port data-memory bus. It takes the decoded lsuop_t from lsu_pkg, plus the address and store data, and drives a req/gnt/rvalid memory handshake. It generates byte strobes and store-data lane replication, and formats load data with sign or zero extension. It stalls the pipeline until the access completes.

Parameters:
TIMEOUT_CYCLES, 0, max cycles from entering REQ until response; 0 = timeout disabled.

Ports:
clk  in  1  clock, rising edge
arst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  MEM stage holds a memory op
lsuop_i  in  5  lsu_pkg::lsuop_t; LB=0 LH=1 LW=2 LBU=3 LHU=4 SB=5 SH=6 SW=7
addr_i  in  32  byte address
wdata_i  in  32  store data, right-aligned
stall_o  out  1  hold pipeline
misaligned_o  out  1  combinational misalignment flag
rdata_o  out  32  formatted load result
rdata_valid_o  out  1  one-cycle completion pulse
err_o  out  1  one-cycle timeout pulse, coincident with rdata_valid_o
mem_req_o  out  1  bus request
mem_we_o  out  1  1 = write
mem_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-replicated store data
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  response valid (store acknowledge or load data)
mem_rdata_i  in  32  load word

Behaviour:
- Reset: async on arst_n low. FSM goes to IDLE. All registered outputs, internal op/addr/data registers and the counter clear to 0. Reset mid-transaction abandons the transaction; a late mem_rvalid_i is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- Misalignment (combinational, from lsuop_i/addr_i): LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. misaligned_o = req_valid_i & misaligned & state==IDLE.
- Op codes 8..31 are no-ops: no request, no stall, misaligned_o=0.
- IDLE, entered on req_valid_i & valid op & aligned: latch op, addr, wdata; go to REQ.
- IDLE, misaligned: stay in IDLE, no bus activity, stall_o=0 (trap handled downstream).
- REQ: mem_req_o=1. Address, be, we and wdata are driven from the latched registers and held stable until grant. On mem_gnt_i go to WAIT; a same-cycle mem_rvalid_i is ignored.
- WAIT: on mem_rvalid_i, register the formatted result into rdata_o and go to DONE.
- DONE: rdata_valid_o=1 for exactly one cycle, stall_o=0, then go to IDLE unconditionally. The pipeline advances on this edge; the next op is accepted in IDLE on the following cycle (one bubble between back-to-back ops).
- stall_o = (IDLE & req_valid_i & valid op & !misaligned) | REQ | WAIT.
- Byte enables:
  - SB: 4'b0001<<addr[1:0]
  - SH: 4'b0011<<{addr[1],1'b0}
  - SW and all loads: 4'b1111
- mem_we_o=1 only for SB/SH/SW.
- Store data: SB replicates wdata[7:0] x4; SH replicates wdata[15:0] x2; SW passes through unchanged.
- Load format: select byte by addr[1:0] or half by addr[1].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass through.
  - Stores: rdata_o=0.
  - rdata_o holds its value until the next completion.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - Reaching TIMEOUT_CYCLES in REQ or WAIT goes to DONE with err_o=1, rdata_o=0 and mem_req_o dropped.
  - A later stray mem_rvalid_i in IDLE is ignored.
- mem_rvalid_i and mem_gnt_i in IDLE or DONE are ignored.

Test Plan:
1. LB, addr=0x1003, grant and rvalid one cycle each, mem_rdata_i=0x80FF_FF00 -> mem_addr_o=0x1000, be=1111, we=0. rdata_o=0xFFFF_FF80 and rdata_valid_o pulse 3 cycles after accept; stall_o high for those 3 cycles.
2. SH, addr=0x2002, wdata=0x1234_ABCD, gnt delayed 4 cycles -> mem_req_o held 5 cycles with be=1100, wdata=0xABCD_ABCD, we=1 stable; stall_o stays high until DONE.
3. LW addr=0x3001 and LHU addr=0x3003 -> misaligned_o=1, stall_o=0, mem_req_o never asserted. LHU addr=0x3002 with rdata 0xBEEF_0000 -> rdata_o=0x0000_BEEF.
4. TIMEOUT_CYCLES=8, LW granted, no rvalid -> err_o=1 and rdata_valid_o=1 in the same cycle, rdata_o=0, FSM back in IDLE. A stray rvalid afterwards produces no pulse.
5. arst_n pulsed low while in WAIT, then rvalid arrives -> all outputs 0, stall_o=0, no rdata_valid_o.
6. Back-to-back SB 0x10 (wdata 0x5A) then LBU 0x10 (rdata 0x0000_005A) -> be=0001, wdata=0x5A5A_5A5A. Second op accepted the cycle after DONE; rdata_o=0x0000_005A.
